// File: rtl/jt49_nch_pkg.sv
// jt49_nch_pkg: shared constants for the N-channel PSG.
// Holds the log-to-linear volume table, the register offset helpers and the
// LFSR geometry used by the optional noise generator.
package jt49_nch_pkg;

  // Noise LFSR: x^17 + x^14 + 1, shifting right with feedback into the MSB.
  // The output/feedback taps are bit 0 and bit 17-14 = 3.
  localparam int                LFSR_W    = 17;
  localparam int                LFSR_FB_A = 0;
  localparam int                LFSR_FB_B = 3;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 17'h1;

  // Control registers sit right after the 2*CH per-channel registers.
  function automatic int REG_TEN(input int ch);
    return 2 * ch;
  endfunction

  function automatic int REG_NEN(input int ch);
    return 2 * ch + 1;
  endfunction

  function automatic int REG_NPER(input int ch);
    return 2 * ch + 2;
  endfunction

  // Roughly 3 dB per step, 0 is silence and 15 is full scale.
  function automatic logic [7:0] vol2lin(input logic [3:0] vol);
    logic [7:0] lin;
    case (vol)
      4'd0:    lin = 8'd0;
      4'd1:    lin = 8'd2;
      4'd2:    lin = 8'd3;
      4'd3:    lin = 8'd4;
      4'd4:    lin = 8'd5;
      4'd5:    lin = 8'd8;
      4'd6:    lin = 8'd11;
      4'd7:    lin = 8'd16;
      4'd8:    lin = 8'd22;
      4'd9:    lin = 8'd32;
      4'd10:   lin = 8'd45;
      4'd11:   lin = 8'd64;
      4'd12:   lin = 8'd90;
      4'd13:   lin = 8'd127;
      4'd14:   lin = 8'd180;
      default: lin = 8'd255;
    endcase
    return lin;
  endfunction

endpackage

// File: rtl/jt49_nch_if.sv
// jt49_nch_if: CPU-side register bus of the PSG.
// Bus semantics: a write is taken on every clk edge where cs_n and wr_n are
// both low, with no back-pressure and no dependence on clk_en; dout is a
// registered image of the register selected by addr on the previous clk.
interface jt49_nch_if;
  logic       cs_n;
  logic       wr_n;
  logic [4:0] addr;
  logic [7:0] din;
  logic [7:0] dout;

  modport master (output cs_n, output wr_n, output addr, output din, input dout);
  modport slave  (input cs_n, input wr_n, input addr, input din, output dout);
endinterface

// File: rtl/jt49_nch_tone.sv
// jt49_nch_tone: one tone channel period counter and square-wave toggle bit.
module jt49_nch_tone #(
  parameter int PW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen_i,
  input  logic [PW-1:0] period_i,
  output logic          tone_o
);

  logic [PW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] limit;
  logic          tone_q, tone_d;

  // Next count: period 0 behaves as period 1; a period shrunk below the
  // current count wraps on the very next tick thanks to the >= compare.
  always_comb begin
    limit  = (period_i == '0) ? '0 : period_i - PW'(1);
    cnt_d  = cnt_q;
    tone_d = tone_q;
    if (cen_i) begin
      if (cnt_q >= limit) begin
        cnt_d  = '0;
        tone_d = ~tone_q;
      end else begin
        cnt_d = cnt_q + PW'(1);
      end
    end
  end

  // Counter and tone state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tone_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tone_q <= tone_d;
    end
  end

  assign tone_o = tone_q;

endmodule

// File: rtl/jt49_nch.sv
// jt49_nch: N-channel programmable sound generator with a time-multiplexed
// linear mixer. Define JT49_NCH_NOISE_EN to build the shared LFSR noise
// source; without it noise is a constant 1 and its registers read 0.
module jt49_nch
  import jt49_nch_pkg::*;
#(
  parameter int CH = 3,
  parameter int PW = 12,
  parameter int OW = 8 + $clog2(CH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clk_en,
  jt49_nch_if.slave     bus,
  output logic [OW-1:0] sound,
  output logic          sample,
  output logic [CH-1:0] ch_bit
);

  localparam int         IW    = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [4:0] A_TEN = 5'(REG_TEN(CH));

  logic [PW-1:0] per_q [CH];
  logic [3:0]    vol_q [CH];
  logic [CH-1:0] ten_q;
  logic [CH-1:0] nen;
  logic          noise;
  logic          wr_en;
  logic [7:0]    rdata_d, dout_q;
  logic [3:0]    pre_q;
  logic          cen16;
  logic [CH-1:0] tone;
  logic [7:0]    lin [CH];

  assign wr_en = ~bus.cs_n & ~bus.wr_n;

  // Period, volume and tone-enable registers; CPU writes ignore clk_en
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CH; c++) begin
        per_q[c] <= '0;
        vol_q[c] <= '0;
      end
      ten_q <= '0;
    end else if (wr_en) begin
      for (int c = 0; c < CH; c++) begin
        if (bus.addr == 5'(2 * c)) per_q[c][7:0] <= bus.din;
        if (bus.addr == 5'(2 * c + 1)) begin
          per_q[c][PW-1:8] <= bus.din[PW-9:0];
          vol_q[c]         <= bus.din[7:4];
        end
      end
      if (bus.addr == A_TEN) ten_q <= bus.din[CH-1:0];
    end
  end

`ifdef JT49_NCH_NOISE_EN
  localparam logic [4:0] A_NEN  = 5'(REG_NEN(CH));
  localparam logic [4:0] A_NPER = 5'(REG_NPER(CH));

  logic [CH-1:0]     nen_q;
  logic [4:0]        nper_q;
  logic [4:0]        ncnt_q, ncnt_d, nlim;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  // Noise enable mask and noise period registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nen_q  <= '0;
      nper_q <= '0;
    end else if (wr_en) begin
      if (bus.addr == A_NEN)  nen_q  <= bus.din[CH-1:0];
      if (bus.addr == A_NPER) nper_q <= bus.din[4:0];
    end
  end

  // Noise divider: the LFSR steps once every nper cen16 ticks (0 acts as 1)
  always_comb begin
    nlim   = (nper_q == '0) ? '0 : nper_q - 5'd1;
    ncnt_d = ncnt_q;
    lfsr_d = lfsr_q;
    if (cen16) begin
      if (ncnt_q >= nlim) begin
        ncnt_d = '0;
        lfsr_d = {lfsr_q[LFSR_FB_A] ^ lfsr_q[LFSR_FB_B], lfsr_q[LFSR_W-1:1]};
      end else begin
        ncnt_d = ncnt_q + 5'd1;
      end
    end
  end

  // Noise divider and LFSR state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ncnt_q <= '0;
      lfsr_q <= LFSR_SEED;
    end else begin
      ncnt_q <= ncnt_d;
      lfsr_q <= lfsr_d;
    end
  end

  assign nen   = nen_q;
  assign noise = lfsr_q[0];
`else
  assign nen   = '0;
  assign noise = 1'b1;
`endif

  // Read mux: implemented bits only, everything else reads as 0
  always_comb begin
    rdata_d = '0;
    for (int c = 0; c < CH; c++) begin
      if (bus.addr == 5'(2 * c))     rdata_d = per_q[c][7:0];
      if (bus.addr == 5'(2 * c + 1)) rdata_d = {vol_q[c], 4'(per_q[c][PW-1:8])};
    end
    if (bus.addr == A_TEN) rdata_d = 8'(ten_q);
`ifdef JT49_NCH_NOISE_EN
    if (bus.addr == A_NEN)  rdata_d = 8'(nen_q);
    if (bus.addr == A_NPER) rdata_d = {3'b000, nper_q};
`endif
  end

  // Registered read data, refreshed every clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dout_q <= '0;
    else        dout_q <= rdata_d;
  end

  assign bus.dout = dout_q;

  // Divide-by-16 prescaler on clk_en pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      pre_q <= '0;
    else if (clk_en) pre_q <= pre_q + 4'd1;
  end

  assign cen16 = clk_en & (pre_q == 4'hF);

  for (genvar c = 0; c < CH; c++) begin : g_tone
    jt49_nch_tone #(.PW(PW)) u_tone (
      .clk      (clk),
      .rst_n    (rst_n),
      .cen_i    (cen16),
      .period_i (per_q[c]),
      .tone_o   (tone[c])
    );
  end

  // A disabled source is forced to 1 so it does not mute the channel
  assign ch_bit = (tone | ~ten_q) & ({CH{noise}} | ~nen);

  // Per-channel linear level after gating
  always_comb begin
    for (int c = 0; c < CH; c++) begin
      lin[c] = ch_bit[c] ? vol2lin(vol_q[c]) : 8'd0;
    end
  end

  // Mixer: idx walks the channels, one per clk_en, accumulating a frame
  logic [IW-1:0] idx_q, idx_d;
  logic [OW-1:0] acc_q, acc_d, sound_q, sound_d;
  logic          sample_q, sample_d;
  logic          last;

  assign last = (idx_q == IW'(CH - 1));

  // Mixer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= '0;
      acc_q    <= '0;
      sound_q  <= '0;
      sample_q <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      sound_q  <= sound_d;
      sample_q <= sample_d;
    end
  end

  // Mixer next state: advance the channel index on every clk_en
  always_comb begin
    idx_d = idx_q;
    if (clk_en) idx_d = last ? '0 : idx_q + IW'(1);
  end

  // Mixer outputs: accumulate, publish the frame sum on the last channel
  always_comb begin
    acc_d    = acc_q;
    sound_d  = sound_q;
    sample_d = 1'b0;
    if (clk_en) begin
      acc_d = ((idx_q == '0) ? '0 : acc_q) + OW'(lin[idx_q]);
      if (last) begin
        sound_d  = acc_d;
        sample_d = 1'b1;
      end
    end
  end

  assign sound  = sound_q;
  assign sample = sample_q;

endmodule

// File: tb/tb_jt49_nch.sv
// tb_jt49_nch: two instances (CH=3/PW=12 and CH=8/PW=10) sharing clock,
// reset and clk_en. Frame sums are predicted into per-instance queues and
// popped by a sample monitor. Noise checks follow JT49_NCH_NOISE_EN.
`timescale 1ns/1ps
module tb_jt49_nch;

  localparam int CH_A = 3;
  localparam int PW_A = 12;
  localparam int CH_B = 8;
  localparam int PW_B = 10;
  localparam int OW_A = 8 + $clog2(CH_A);
  localparam int OW_B = 8 + $clog2(CH_B);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            clk_en = 1'b0;
  logic [OW_A-1:0] sound_a;
  logic            sample_a;
  logic [CH_A-1:0] ch_bit_a;
  logic [OW_B-1:0] sound_b;
  logic            sample_b;
  logic [CH_B-1:0] ch_bit_b;

  jt49_nch_if bus_a ();
  jt49_nch_if bus_b ();

  jt49_nch #(.CH(CH_A), .PW(PW_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .bus(bus_a),
    .sound(sound_a), .sample(sample_a), .ch_bit(ch_bit_a)
  );

  jt49_nch #(.CH(CH_B), .PW(PW_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .bus(bus_b),
    .sound(sound_b), .sample(sample_b), .ch_bit(ch_bit_b)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  int          n_ce = 0;
  int          ce_tot = 0;
  int          last_a = 0;
  int          last_b = 0;
  bit          sb_a_on = 1'b0;
  bit          sb_b_on = 1'b0;
  logic [10:0] exp_a_q[$];
  logic [10:0] exp_b_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic en);
    clk_en = en;
    @(posedge clk);
    #1;
    if (en) n_ce++;
  endtask

  task automatic do_reset();
    clk_en = 1'b0;
    rst_n  = 1'b0;
    repeat (2) step(1'b0);
    rst_n = 1'b1;
    n_ce  = 0;
    step(1'b0);
  endtask

  task automatic bus_wr(input int d, input logic [4:0] a, input logic [7:0] v);
    if (d == 0) begin
      bus_a.cs_n = 1'b0; bus_a.wr_n = 1'b0; bus_a.addr = a; bus_a.din = v;
    end else begin
      bus_b.cs_n = 1'b0; bus_b.wr_n = 1'b0; bus_b.addr = a; bus_b.din = v;
    end
    step(1'b0);
    bus_a.cs_n = 1'b1; bus_a.wr_n = 1'b1;
    bus_b.cs_n = 1'b1; bus_b.wr_n = 1'b1;
  endtask

  task automatic bus_rd(input int d, input logic [4:0] a, output logic [7:0] v);
    if (d == 0) bus_a.addr = a;
    else        bus_b.addr = a;
    step(1'b0);
    v = (d == 0) ? bus_a.dout : bus_b.dout;
  endtask

  task automatic set_full_vol();
    for (int c = 0; c < CH_A; c++) bus_wr(0, 5'(2 * c + 1), 8'hF0);
    for (int c = 0; c < CH_B; c++) bus_wr(1, 5'(2 * c + 1), 8'hF0);
  endtask

  // ---------------- scoreboard ----------------
  always @(posedge clk) if (clk_en && rst_n) ce_tot <= ce_tot + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      last_a = ce_tot;
      last_b = ce_tot;
    end else begin
      if (sample_a) begin
        if (sb_a_on) begin
          check_eq("spacing_a", ce_tot - last_a, CH_A);
          if (exp_a_q.size() == 0) check_eq("sb_a_pending", exp_a_q.size(), 1);
          else                     check_eq("sound_a", sound_a, exp_a_q.pop_front());
        end
        last_a = ce_tot;
      end
      if (sample_b) begin
        if (sb_b_on) begin
          check_eq("spacing_b", ce_tot - last_b, CH_B);
          if (exp_b_q.size() == 0) check_eq("sb_b_pending", exp_b_q.size(), 1);
          else                     check_eq("sound_b", sound_b, exp_b_q.pop_front());
        end
        last_b = ce_tot;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0]  v;
    logic [16:0] m;
    int          guard;

    bus_a.cs_n = 1'b1; bus_a.wr_n = 1'b1; bus_a.addr = '0; bus_a.din = '0;
    bus_b.cs_n = 1'b1; bus_b.wr_n = 1'b1; bus_b.addr = '0; bus_b.din = '0;

    // Reset state
    do_reset();
    check_eq("rst_sound_a", sound_a, 0);
    check_eq("rst_sample_a", sample_a, 0);
    check_eq("rst_ch_bit_a", ch_bit_a, 3'b111);
    check_eq("rst_dout_a", bus_a.dout, 0);
    check_eq("rst_sound_b", sound_b, 0);
    check_eq("rst_ch_bit_b", ch_bit_b, 8'hFF);

    // Readback and masking
    bus_wr(1, 5'd1, 8'hFF);  bus_rd(1, 5'd1, v);  check_eq("rd_b_r1_mask", v, 8'hF3);
    bus_wr(1, 5'd31, 8'hFF); bus_rd(1, 5'd31, v); check_eq("rd_b_a31", v, 8'h00);
    bus_wr(1, 5'd16, 8'h5A); bus_rd(1, 5'd16, v); check_eq("rd_b_ten", v, 8'h5A);
    bus_wr(0, 5'd0, 8'hA5);  bus_rd(0, 5'd0, v);  check_eq("rd_a_r0", v, 8'hA5);
    bus_wr(0, 5'd1, 8'hFF);  bus_rd(0, 5'd1, v);  check_eq("rd_a_r1", v, 8'hFF);
    bus_wr(0, 5'd6, 8'hFF);  bus_rd(0, 5'd6, v);  check_eq("rd_a_ten_mask", v, 8'h07);
    bus_wr(0, 5'd9, 8'hFF);  bus_rd(0, 5'd9, v);  check_eq("rd_a_unmapped", v, 8'h00);
    bus_wr(0, 5'd7, 8'hFF);  bus_rd(0, 5'd7, v);
`ifdef JT49_NCH_NOISE_EN
    check_eq("rd_a_nen", v, 8'h07);
    bus_wr(0, 5'd8, 8'hFF);  bus_rd(0, 5'd8, v);  check_eq("rd_a_nper", v, 8'h1F);
`else
    check_eq("rd_a_nen_off", v, 8'h00);
    bus_wr(0, 5'd8, 8'hFF);  bus_rd(0, 5'd8, v);  check_eq("rd_a_nper_off", v, 8'h00);
`endif

    // Tone period 4 on channel 0 at full volume
    do_reset();
    bus_wr(0, 5'd0, 8'd4);
    bus_wr(0, 5'd1, 8'hF0);
    bus_wr(0, 5'd6, 8'h01);
    for (int f = 0; f < 100; f++) exp_a_q.push_back(11'((((3 * f) / 64) % 2) ? 255 : 0));
    sb_a_on = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step(1'b1);
      if ((n_ce % 64) == 0 || (n_ce % 64) == 63) check_eq("tone_a0", ch_bit_a[0], (n_ce / 64) % 2);
    end
    check_eq("ch_bit_a_off", ch_bit_a[2:1], 2'b11);
    step(1'b0);
    sb_a_on = 1'b0;
    check_eq("q_a_drained_tone", exp_a_q.size(), 0);

    // Period 0 must toggle exactly like period 1
    do_reset();
    bus_wr(0, 5'd0, 8'd0);
    bus_wr(0, 5'd2, 8'd1);
    bus_wr(0, 5'd6, 8'h03);
    for (int i = 0; i < 96; i++) begin
      step(1'b1);
      if ((n_ce % 16) == 8) begin
        check_eq("per0_tone", ch_bit_a[0], (n_ce / 16) % 2);
        check_eq("per1_tone", ch_bit_a[1], (n_ce / 16) % 2);
      end
    end

    // Mixer sum with all enables off and full volume, random clk_en
    do_reset();
    set_full_vol();
    for (int f = 0; f < 32; f++) exp_a_q.push_back(11'd765);
    for (int f = 0; f < 12; f++) exp_b_q.push_back(11'd2040);
    sb_a_on = 1'b1;
    sb_b_on = 1'b1;
    guard = 0;
    while (n_ce < 96 && guard < 5000) begin
      step(1'($urandom_range(0, 1)));
      guard++;
    end
    check_eq("mix_ce_reached", n_ce, 96);
    step(1'b0);
    check_eq("q_a_drained_mix", exp_a_q.size(), 0);
    check_eq("q_b_drained_mix", exp_b_q.size(), 0);

    // Reset mid-frame at idx 1
    step(1'b1);
    sb_a_on = 1'b0;
    sb_b_on = 1'b0;
    check_eq("pre_rst_sound_a", sound_a, 765);
    check_eq("pre_rst_sound_b", sound_b, 2040);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_sound_a", sound_a, 0);
    check_eq("midrst_sample_a", sample_a, 0);
    check_eq("midrst_sound_b", sound_b, 0);
    check_eq("midrst_sample_b", sample_b, 0);
    step(1'b0);
    step(1'b0);
    rst_n = 1'b1;
    n_ce  = 0;
    set_full_vol();
    for (int f = 0; f < 8; f++) exp_a_q.push_back(11'd765);
    for (int f = 0; f < 3; f++) exp_b_q.push_back(11'd2040);
    sb_a_on = 1'b1;
    sb_b_on = 1'b1;
    for (int i = 0; i < 24; i++) step(1'b1);
    step(1'b0);
    sb_a_on = 1'b0;
    sb_b_on = 1'b0;
    check_eq("q_a_drained_rst", exp_a_q.size(), 0);
    check_eq("q_b_drained_rst", exp_b_q.size(), 0);

`ifdef JT49_NCH_NOISE_EN
    // Noise on channel 0, tone disabled, LFSR stepping every cen16
    do_reset();
    bus_wr(0, 5'd8, 8'd1);
    bus_wr(0, 5'd7, 8'h01);
    m = 17'h1;
    for (int k = 0; k < 24; k++) begin
      while (n_ce < 16 * k + 8) step(1'b1);
      check_eq("noise_a0", ch_bit_a[0], m[0]);
      m = {m[0] ^ m[3], m[16:1]};
    end
    check_eq("noise_a1_off", ch_bit_a[1], 1);
`else
    m = '0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
